// File: rtl/ps2_keyboard_sequencer.sv
// PS/2 keyboard bring-up (0xFF reset, ACK 0xFA, BAT 0xAA, bounded retries) followed by Set-2 decoding
// of the scan-code stream into held key levels; all outputs registered, keys update one cycle after the final byte.
module ps2_keyboard_sequencer #(
    parameter int unsigned RESP_TIMEOUT = 50_000_000,
    parameter int unsigned RETRY_LIMIT  = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    output logic [7:0] the_command,
    output logic       send_command,
    output logic       init_done,
    output logic       init_error,
    output logic       key_left,
    output logic       key_right,
    output logic       key_up,
    output logic       key_down,
    output logic       key_space,
    output logic       key_enter,
    output logic       key_esc,
    output logic       key_event
);

    typedef enum logic [2:0] {
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_RETRY,
        S_RUN
    } state_t;

    localparam logic [25:0] TIMER_LAST  = 26'(RESP_TIMEOUT - 1);
    localparam logic [3:0]  ATTEMPT_MAX = 4'(RETRY_LIMIT);

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_UP    = 2;
    localparam int K_DOWN  = 3;
    localparam int K_SPACE = 4;
    localparam int K_ENTER = 5;
    localparam int K_ESC   = 6;

    state_t      state_q;
    logic [25:0] timer_q;
    logic [3:0]  attempts_q;
    logic [3:0]  attempts_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [6:0]  keys_q, keys_d;
    logic [7:0]  cmd_q;
    logic        send_q;
    logic        done_q;
    logic        err_q;
    logic        event_q;

    logic rx_ack, rx_resend, rx_bat_ok, rx_bat_fail, timeout;

    assign rx_ack      = received_data_en && (received_data == 8'hFA);
    assign rx_resend   = received_data_en && (received_data == 8'hFE);
    assign rx_bat_ok   = received_data_en && (received_data == 8'hAA);
    assign rx_bat_fail = received_data_en && (received_data == 8'hFC);
    assign timeout     = (timer_q == TIMER_LAST);
    assign attempts_d  = attempts_q + 4'd1;

    // Scan-code decode; only committed to state while in RUN.
    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (received_data_en) begin
            case (received_data)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hFF: begin
                    keys_d = '0;
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (ext_q) begin
                        case (received_data)
                            8'h6B:   keys_d[K_LEFT]  = ~brk_q;
                            8'h74:   keys_d[K_RIGHT] = ~brk_q;
                            8'h75:   keys_d[K_UP]    = ~brk_q;
                            8'h72:   keys_d[K_DOWN]  = ~brk_q;
                            default: ;
                        endcase
                    end else begin
                        case (received_data)
                            8'h29:   keys_d[K_SPACE] = ~brk_q;
                            8'h5A:   keys_d[K_ENTER] = ~brk_q;
                            8'h76:   keys_d[K_ESC]   = ~brk_q;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_SEND;
            timer_q    <= '0;
            attempts_q <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            keys_q     <= '0;
            cmd_q      <= 8'hFF;
            send_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            event_q    <= 1'b0;
        end else begin
            event_q <= 1'b0;
            timer_q <= '0;
            case (state_q)
                S_SEND: begin
                    send_q  <= 1'b1;
                    cmd_q   <= 8'hFF;
                    state_q <= S_WAIT_SENT;
                end
                S_WAIT_SENT: begin
                    if (command_was_sent) begin
                        send_q  <= 1'b0;
                        state_q <= S_WAIT_ACK;
                    end else if (error_communication_timed_out) begin
                        send_q  <= 1'b0;
                        state_q <= S_RETRY;
                    end
                end
                S_WAIT_ACK: begin
                    // An expected byte in the timeout cycle takes precedence.
                    if (rx_ack)                  state_q <= S_WAIT_BAT;
                    else if (rx_resend)          state_q <= S_RETRY;
                    else if (timeout)            state_q <= S_RETRY;
                    else                         timer_q <= timer_q + 26'd1;
                end
                S_WAIT_BAT: begin
                    if (rx_bat_ok) begin
                        done_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else if (rx_bat_fail || timeout) begin
                        state_q <= S_RETRY;
                    end else begin
                        timer_q <= timer_q + 26'd1;
                    end
                end
                S_RETRY: begin
                    attempts_q <= attempts_d;
                    if (attempts_d == ATTEMPT_MAX) begin
                        err_q   <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_SEND;
                    end
                end
                S_RUN: begin
                    ext_q   <= ext_d;
                    brk_q   <= brk_d;
                    keys_q  <= keys_d;
                    event_q <= (keys_d != keys_q);
                end
                default: state_q <= S_SEND;
            endcase
        end
    end

    assign the_command  = cmd_q;
    assign send_command = send_q;
    assign init_done    = done_q;
    assign init_error   = err_q;
    assign key_event    = event_q;
    assign key_left     = keys_q[K_LEFT];
    assign key_right    = keys_q[K_RIGHT];
    assign key_up       = keys_q[K_UP];
    assign key_down     = keys_q[K_DOWN];
    assign key_space    = keys_q[K_SPACE];
    assign key_enter    = keys_q[K_ENTER];
    assign key_esc      = keys_q[K_ESC];

endmodule

// File: tb/tb_ps2_keyboard_sequencer.sv
// Bench for ps2_keyboard_sequencer: directed bring-up/retry flows plus randomized key actions
// checked against a key-level model (pressed/released per named key).
module tb_ps2_keyboard_sequencer;

    localparam int RT = 1000;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] the_command;
    logic       send_command, init_done, init_error;
    logic       key_left, key_right, key_up, key_down, key_space, key_enter, key_esc, key_event;
    logic [6:0] dut_keys;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int pulse_base;
    logic send_prev = 1'b0;

    // Model: pressed state per key (left,right,up,down,space,enter,esc).
    logic [6:0] mk = '0;
    logic [7:0] code_tbl [7] = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h5A, 8'h76};

    ps2_keyboard_sequencer #(.RESP_TIMEOUT(RT), .RETRY_LIMIT(3)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .the_command(the_command), .send_command(send_command),
        .init_done(init_done), .init_error(init_error),
        .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
        .key_space(key_space), .key_enter(key_enter), .key_esc(key_esc),
        .key_event(key_event)
    );

    assign dut_keys = {key_esc, key_enter, key_space, key_down, key_up, key_right, key_left};

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (send_command && !send_prev) pulses <= pulses + 1;
        send_prev <= send_command;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        tick();
        received_data_en = 1'b0;
        received_data    = 8'(($urandom_range(0, 255)));
    endtask

    task automatic wait_send(input string tag);
        int n;
        n = 0;
        while (send_command !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, send_command, 1);
        check_eq({tag, "_cmd"}, the_command, 8'hFF);
    endtask

    task automatic ack_cmd();
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
        check_eq("send_fall", send_command, 0);
    endtask

    task automatic check_reset();
        check_eq("rst_send", send_command, 0);
        check_eq("rst_cmd", the_command, 8'hFF);
        check_eq("rst_done", init_done, 0);
        check_eq("rst_err", init_error, 0);
        check_eq("rst_keys", dut_keys, 0);
        check_eq("rst_evt", key_event, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check_reset();
        reset = 1'b0;
        mk = '0;
        tick();
        check_eq("send_rise_after_reset", send_command, 1);
    endtask

    function automatic bit is_taken(input bit ext, input logic [7:0] c);
        if (c == 8'hE0 || c == 8'hF0 || c == 8'h00 || c == 8'hFF) return 1'b1;
        for (int i = 0; i < 7; i++)
            if (code_tbl[i] == c && ((i < 4) == ext)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] pick_unmapped(input bit ext);
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        while (is_taken(ext, c)) c = 8'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic key_op(input int k, input bit rel);
        logic [6:0] prev;
        prev = mk;
        repeat ($urandom_range(0, 2)) tick();
        if (k < 4) begin
            send_byte(8'hE0);
            check_eq("evt_after_e0", key_event, 0);
        end
        if (rel) begin
            send_byte(8'hF0);
            check_eq("evt_after_f0", key_event, 0);
        end
        send_byte(code_tbl[k]);
        mk[k] = ~rel;
        check_eq("keys", dut_keys, mk);
        check_eq("key_event", key_event, prev != mk);
        tick();
        check_eq("evt_one_cycle", key_event, 0);
    endtask

    task automatic unmapped_op(input bit ext, input bit rel, input logic [7:0] c);
        if (ext) send_byte(8'hE0);
        if (rel) send_byte(8'hF0);
        send_byte(c);
        check_eq("unmapped_keys", dut_keys, mk);
        check_eq("unmapped_evt", key_event, 0);
    endtask

    task automatic overrun_op(input logic [7:0] b);
        logic [6:0] prev;
        prev = mk;
        send_byte(b);
        mk = '0;
        check_eq("overrun_keys", dut_keys, 0);
        check_eq("overrun_evt", key_event, prev != 0);
        tick();
        check_eq("overrun_evt_once", key_event, 0);
    endtask

    initial begin
        int r;
        // Reset state
        tick();
        tick();
        check_reset();

        // Nominal bring-up with stray bytes in every waiting state
        do_reset();
        send_byte(8'hE0);
        check_eq("send_held", send_command, 1);
        repeat ($urandom_range(0, 4)) tick();
        check_eq("send_held2", send_command, 1);
        ack_cmd();
        send_byte(8'hF0);
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hE0);
        send_byte(8'hFA);
        check_eq("done_before_bat", init_done, 0);
        send_byte(8'hAA);
        check_eq("init_done", init_done, 1);
        check_eq("init_err_nominal", init_error, 0);
        check_eq("send_low_run", send_command, 0);
        check_eq("cmd_run", the_command, 8'hFF);

        // Directed decode cases
        key_op(4, 1'b0);
        key_op(4, 1'b1);
        key_op(0, 1'b0);
        key_op(0, 1'b0);
        key_op(0, 1'b1);
        key_op(5, 1'b0);
        unmapped_op(1'b1, 1'b0, 8'h5A);
        unmapped_op(1'b1, 1'b1, 8'h5A);
        key_op(5, 1'b1);
        unmapped_op(1'b1, 1'b0, 8'h1C);
        unmapped_op(1'b0, 1'b0, 8'h6B);
        unmapped_op(1'b0, 1'b0, 8'hE1);
        key_op(0, 1'b0);
        key_op(4, 1'b0);
        overrun_op(8'h00);

        // Randomized key actions against the key-level model
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 15)
                key_op(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            else if (r < 19) begin
                r = int'($urandom_range(0, 1));
                unmapped_op(r[0], 1'($urandom_range(0, 1)), pick_unmapped(r[0]));
            end else
                overrun_op(($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00);
        end
        check_eq("send_never_in_run", pulses, 1);

        // Reset with a key held, then reset while waiting for BAT
        key_op(0, 1'b0);
        do_reset();
        ack_cmd();
        send_byte(8'hFA);
        pulse_base = pulses;
        do_reset();

        // Retries: FE, ACK timeout, then BAT failure
        ack_cmd();
        send_byte(8'hFE);
        check_eq("retry_send_low1", send_command, 0);
        tick();
        check_eq("retry_send_low2", send_command, 0);
        tick();
        check_eq("retry_send_rise", send_command, 1);
        ack_cmd();
        repeat (RT + 1) tick();
        check_eq("ack_timeout_not_yet", send_command, 0);
        tick();
        check_eq("ack_timeout_resend", send_command, 1);
        ack_cmd();
        send_byte(8'hFA);
        send_byte(8'h55);
        send_byte(8'hFC);
        check_eq("err_before_retry", init_error, 0);
        tick();
        check_eq("init_error", init_error, 1);
        check_eq("done_after_fail", init_done, 0);
        repeat (5) tick();
        check_eq("send_idle_after_fail", send_command, 0);
        check_eq("send_pulses", pulses - pulse_base, 3);
        key_op(4, 1'b0);
        key_op(1, 1'b0);
        key_op(1, 1'b1);

        // BAT accepted in the very cycle the timeout would fire
        do_reset();
        ack_cmd();
        send_byte(8'hFA);
        repeat (RT - 1) tick();
        send_byte(8'hAA);
        check_eq("bat_at_timeout", init_done, 1);
        check_eq("bat_at_timeout_err", init_error, 0);

        // Unexpected byte at ACK timeout, then transceiver timeouts exhaust retries
        do_reset();
        ack_cmd();
        repeat (RT - 1) tick();
        send_byte(8'h33);
        tick();
        check_eq("stray_at_timeout_low", send_command, 0);
        tick();
        check_eq("stray_at_timeout_resend", send_command, 1);
        for (int a = 0; a < 2; a++) begin
            wait_send("wait_send_tx_to");
            error_communication_timed_out = 1'b1;
            tick();
            error_communication_timed_out = 1'b0;
            check_eq("tx_to_send_fall", send_command, 0);
        end
        tick();
        check_eq("tx_to_init_error", init_error, 1);
        check_eq("tx_to_init_done", init_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
